// File: rtl/slave_port_split_pkg.sv
// Shared types and defaults for the serial-bus slave port family.
// Serial address and data fields travel LSB first.
package slave_port_split_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_STROBE,
        ST_SPLIT,
        ST_WAIT_GNT,
        ST_TX
    } state_e;

    // Width of a counter that must hold 0..n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/slave_port_split_tx_shifter.sv
// Load/shift/hold parallel-in serial-out register for read data, LSB first.
// Load takes priority over shift; with neither, the current bit is held.
module slave_tx_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = din;
        end else if (shift) begin
            sh_d = sh_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign dout = sh_q[0];

endmodule

// File: rtl/slave_port_split.sv
// Split-capable serial-bus slave port: deserialises address/write data, strobes the
// memory, releases the bus during slow reads, then serialises read data back.
module slave_port_split
    import slave_port_split_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned SPLIT_DELAY = 10,
    parameter int unsigned USE_GRANT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic                  master_valid,
    input  logic                  master_ready,
    input  logic                  rx_address,
    input  logic                  rx_data,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  split_grant,
    output logic                  slave_ready,
    output logic                  slave_valid,
    output logic                  tx_data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  read_en_in,
    output logic                  write_en_in,
    output logic                  split_en
);

    localparam int unsigned RXW = cnt_width(ADDR_WIDTH);
    localparam int unsigned TXW = cnt_width(DATA_WIDTH);
    localparam int unsigned SPW = cnt_width(SPLIT_DELAY);

    localparam logic [RXW-1:0] RX_PEN       = RXW'(ADDR_WIDTH - 1);
    localparam logic [RXW-1:0] RX_DATA_BITS = RXW'(DATA_WIDTH);
    localparam logic [TXW-1:0] TX_PEN       = TXW'(DATA_WIDTH - 1);
    localparam logic [SPW-1:0] SP_LAST      = SPW'(SPLIT_DELAY);

    state_e                state_q, state_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [RXW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [SPW-1:0]        sp_cnt_q, sp_cnt_d;
    logic [TXW-1:0]        tx_cnt_q, tx_cnt_d;
    logic                  slave_ready_q, slave_ready_d;
    logic                  slave_valid_q, slave_valid_d;
    logic                  split_en_q, split_en_d;
    logic                  read_en_in_q, read_en_in_d;
    logic                  write_en_in_q, write_en_in_d;
    logic                  tx_load;
    logic                  tx_shift;
    logic                  tx_bit;

    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        address_d   = address_q;
        data_d      = data_q;
        rx_cnt_d    = rx_cnt_q;
        sp_cnt_d    = sp_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (master_valid && (read_en || write_en)) begin
                    cmd_write_d = write_en;
                    address_d   = {rx_address, address_q[ADDR_WIDTH-1:1]};
                    data_d      = {rx_data, data_q[DATA_WIDTH-1:1]};
                    rx_cnt_d    = RXW'(1);
                    state_d     = ST_RX;
                end
            end
            ST_RX: begin
                if (master_valid) begin
                    address_d = {rx_address, address_q[ADDR_WIDTH-1:1]};
                    if (rx_cnt_q < RX_DATA_BITS) begin
                        data_d = {rx_data, data_q[DATA_WIDTH-1:1]};
                    end
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    if (rx_cnt_q == RX_PEN) begin
                        state_d = ST_STROBE;
                    end
                end
            end
            ST_STROBE: begin
                if (cmd_write_q) begin
                    state_d = ST_IDLE;
                end else begin
                    sp_cnt_d = SPW'(1);
                    state_d  = ST_SPLIT;
                end
            end
            // With no split delay this state is a single silent load cycle.
            ST_SPLIT: begin
                if (SPLIT_DELAY == 0 || sp_cnt_q == SP_LAST) begin
                    tx_load  = 1'b1;
                    tx_cnt_d = '0;
                    state_d  = (USE_GRANT != 0 && SPLIT_DELAY != 0) ? ST_WAIT_GNT : ST_TX;
                end else begin
                    sp_cnt_d = sp_cnt_q + 1'b1;
                end
            end
            ST_WAIT_GNT: begin
                if (split_grant) begin
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (master_ready) begin
                    tx_shift = 1'b1;
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == TX_PEN) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with the state itself.
        slave_ready_d = (state_d == ST_IDLE);
        slave_valid_d = (state_d == ST_TX);
        split_en_d    = (state_d == ST_WAIT_GNT) || ((state_d == ST_SPLIT) && (SPLIT_DELAY != 0));
        read_en_in_d  = (state_d == ST_STROBE) && !cmd_write_d;
        write_en_in_d = (state_d == ST_STROBE) && cmd_write_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cmd_write_q   <= 1'b0;
            address_q     <= '0;
            data_q        <= '0;
            rx_cnt_q      <= '0;
            sp_cnt_q      <= '0;
            tx_cnt_q      <= '0;
            slave_ready_q <= 1'b1;
            slave_valid_q <= 1'b0;
            split_en_q    <= 1'b0;
            read_en_in_q  <= 1'b0;
            write_en_in_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_write_q   <= cmd_write_d;
            address_q     <= address_d;
            data_q        <= data_d;
            rx_cnt_q      <= rx_cnt_d;
            sp_cnt_q      <= sp_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            slave_ready_q <= slave_ready_d;
            slave_valid_q <= slave_valid_d;
            split_en_q    <= split_en_d;
            read_en_in_q  <= read_en_in_d;
            write_en_in_q <= write_en_in_d;
        end
    end

    slave_tx_shifter #(
        .WIDTH(DATA_WIDTH)
    ) u_tx_shifter (
        .clk  (clk),
        .reset(reset),
        .load (tx_load),
        .shift(tx_shift),
        .din  (datain),
        .dout (tx_bit)
    );

    assign slave_ready = slave_ready_q;
    assign slave_valid = slave_valid_q;
    assign tx_data     = slave_valid_q & tx_bit;
    assign address     = address_q;
    assign data        = data_q;
    assign read_en_in  = read_en_in_q;
    assign write_en_in = write_en_in_q;
    assign split_en    = split_en_q;

endmodule
